// File: rtl/signed_mult_seq_ctrl.sv
// Sequential signed multiplier: operands are turned into magnitudes, multiplied by
// N shift-add steps over one N-bit adder, and the sign is applied to the result.
module signed_mult_seq_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, SIGN} state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     a_reg, b_reg, mag_a_reg, hi_reg, lo_reg;
  logic             sign_reg;
  logic [CW-1:0]    count_reg;
  logic [2*N-1:0]   product_reg;
  logic             done_reg;

  logic [N-1:0]     mag_a_c, mag_b_c, step_a_c, step_hi_c, step_lo_c, addend_c;
  logic [N:0]       sum_c;
  logic [N-1:0]     hi_next, lo_next;
  logic [2*N-1:0]   prod_mag_c, product_next;

  assign mag_a_c = a_reg[N-1] ? (~a_reg + 1'b1) : a_reg;
  assign mag_b_c = b_reg[N-1] ? (~b_reg + 1'b1) : b_reg;

  // LOAD performs step 0 on a cleared accumulator, so ITER runs the remaining
  // N-1 steps and a result is ready every N+2 cycles.
  assign step_a_c  = (state_reg == LOAD) ? mag_a_c : mag_a_reg;
  assign step_hi_c = (state_reg == LOAD) ? '0      : hi_reg;
  assign step_lo_c = (state_reg == LOAD) ? mag_b_c : lo_reg;
  assign addend_c  = step_lo_c[0] ? step_a_c : '0;
  assign sum_c     = {1'b0, step_hi_c} + {1'b0, addend_c};
  assign hi_next   = sum_c[N:1];

  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_lo_shift
      assign lo_next[gi] = step_lo_c[gi+1];
    end
  endgenerate
  assign lo_next[N-1] = sum_c[0];

  assign prod_mag_c   = {hi_reg, lo_reg};
  assign product_next = sign_reg ? (~prod_mag_c + 1'b1) : prod_mag_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = ITER;
      ITER:    if (count_reg == CW'(N - 1)) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sign_reg    <= 1'b0;
      mag_a_reg   <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      count_reg   <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= (state_reg == SIGN);
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            sign_reg <= a[N-1] ^ b[N-1];
          end
        end
        LOAD: begin
          mag_a_reg <= mag_a_c;
          hi_reg    <= hi_next;
          lo_reg    <= lo_next;
          count_reg <= CW'(1);
        end
        ITER: begin
          hi_reg    <= hi_next;
          lo_reg    <= lo_next;
          count_reg <= count_reg + 1'b1;
        end
        SIGN: begin
          product_reg <= product_next;
          count_reg   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ready   = (state_reg == IDLE);
  assign busy    = ~ready;
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_signed_mult_seq_ctrl.sv
// Scoreboard bench for signed_mult_seq_ctrl: driver pushes expected products,
// a monitor pops and compares them on every done pulse.
module tb_signed_mult_seq_ctrl;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       ready, busy, done;
  logic [7:0] product;

  always #5 clk = ~clk;

  signed_mult_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  typedef struct {
    logic [7:0] prod;
    int         acc_cyc;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_count = 0;
  int         last_done = 0;
  bit         have_last = 1'b0;
  bit         gap_mode = 1'b0;
  logic [7:0] prev_prod = '0;
  bit         have_prev = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: plain signed integer multiply truncated to 2N bits.
  function automatic logic [7:0] ref_mult(logic [3:0] x, logic [3:0] y);
    int sx, sy, p;
    sx = $signed(x);
    sy = $signed(y);
    p  = sx * sy;
    return p[7:0];
  endfunction

  function automatic exp_t make_exp(logic [3:0] x, logic [3:0] y, int c);
    exp_t e;
    e.prod    = ref_mult(x, y);
    e.acc_cyc = c;
    e.a       = x;
    e.b       = y;
    return e;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_product", product, 8'h00);
        have_last = 1'b0;
      end else begin
        check("busy_vs_ready", busy, !ready);
        if (done) begin
          done_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got product %0h, required no done", product);
          end else begin
            mon_e = exp_q.pop_front();
            $display("txn %0d: a=%0d b=%0d product=%02h expected=%02h", done_count,
                     $signed(mon_e.a), $signed(mon_e.b), product, mon_e.prod);
            check("product", product, mon_e.prod);
            check("latency", cyc - mon_e.acc_cyc, 6);
            if (gap_mode && have_last) check("done_gap", cyc - last_done, 6);
            last_done = cyc;
            have_last = 1'b1;
          end
        end else if (have_prev) begin
          check("product_hold", product, prev_prod);
        end
      end
      prev_prod = product;
      have_prev = 1'b1;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=%0b, required 1", ready);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the capture edge.
  task automatic issue(logic [3:0] x, logic [3:0] y);
    wait_ready();
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(make_exp(x, y, cyc));
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
  endtask

  task automatic directed(logic [3:0] x, logic [3:0] y);
    int n = 0;
    issue(x, y);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 5);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int dc0, idx, guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases, including most-negative operands and zeros.
    directed(4'd3, 4'd5);
    directed(4'h8, 4'h8);
    directed(4'h8, 4'h7);
    directed(4'hF, 4'h1);
    directed(4'h0, 4'hB);
    directed(4'hD, 4'h0);
    for (int i = 0; i < 8; i++) directed(4'($urandom), 4'($urandom));
    drain();

    // start held high; operands change while an operation is in flight.
    gap_mode  = 1'b1;
    have_last = 1'b0;
    dc0 = done_count;
    for (int i = 0; i < 30; i++) begin
      start = 1'b1;
      if (i < 20) begin a = 4'd2;  b = 4'd3; end
      else        begin a = 4'hE;  b = 4'd3; end
      if (ready) exp_q.push_back(make_exp(a, b, cyc));
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    check("held_start_done_count", done_count - dc0, 5);
    gap_mode = 1'b0;

    // Reset in the second ITER cycle aborts the operation silently.
    issue(4'd5, 4'd6);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    dc0 = done_count;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_product", product, 8'h00);
    repeat (8) @(negedge clk);
    check("abort_no_done", done_count - dc0, 0);
    directed(4'h9, 4'h6);
    drain();

    // Exhaustive back-to-back sweep with junk on the inputs while busy.
    gap_mode  = 1'b1;
    have_last = 1'b0;
    dc0   = done_count;
    idx   = 0;
    guard = 0;
    while (idx < 256 && guard < 5000) begin
      if (ready) begin
        a = idx[7:4];
        b = idx[3:0];
        start = 1'b1;
        exp_q.push_back(make_exp(a, b, cyc));
        idx++;
      end else begin
        a = 4'($urandom);
        b = 4'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    drain();
    check("exhaustive_done_count", done_count - dc0, 256);
    gap_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
